// File: rtl/inst_decode.sv
// inst_decode: RV32I decode stage with register file,
// immediate generation, load-use stall and ID/EX register.
module inst_decode #(
  parameter int PC_SIZE      = 32,
  parameter int INS_MEM_SIZE = 32,
  parameter int REG_ADDR     = 5
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic [PC_SIZE+INS_MEM_SIZE-1:0] i_if_id_reg,
  input  logic                            i_wb_we,
  input  logic [REG_ADDR-1:0]             i_wb_addr,
  input  logic [INS_MEM_SIZE-1:0]         i_wb_data,
  input  logic                            i_ex_mem_read,
  input  logic [REG_ADDR-1:0]             i_ex_rd,
  input  logic                            i_flush,
  output logic                            o_stall,
  output logic                            o_id_ex_valid,
  output logic [PC_SIZE-1:0]              o_id_ex_pc,
  output logic [INS_MEM_SIZE-1:0]         o_id_ex_rs1_data,
  output logic [INS_MEM_SIZE-1:0]         o_id_ex_rs2_data,
  output logic [INS_MEM_SIZE-1:0]         o_id_ex_imm,
  output logic [REG_ADDR-1:0]             o_id_ex_rs1,
  output logic [REG_ADDR-1:0]             o_id_ex_rs2,
  output logic [REG_ADDR-1:0]             o_id_ex_rd,
  output logic [2:0]                      o_id_ex_funct3,
  output logic                            o_id_ex_funct7b5,
  output logic                            o_id_ex_reg_write,
  output logic                            o_id_ex_mem_read,
  output logic                            o_id_ex_mem_write,
  output logic                            o_id_ex_mem_to_reg,
  output logic                            o_id_ex_branch,
  output logic                            o_id_ex_alu_src,
  output logic [1:0]                      o_id_ex_alu_op
);

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;
  localparam logic [6:0] OP_BR = 7'b1100011;
  localparam int         NREG  = 2 ** REG_ADDR;

  typedef struct packed {
    logic                    valid;
    logic [PC_SIZE-1:0]      pc;
    logic [INS_MEM_SIZE-1:0] rs1_data;
    logic [INS_MEM_SIZE-1:0] rs2_data;
    logic [INS_MEM_SIZE-1:0] imm;
    logic [REG_ADDR-1:0]     rs1;
    logic [REG_ADDR-1:0]     rs2;
    logic [REG_ADDR-1:0]     rd;
    logic [2:0]              funct3;
    logic                    funct7b5;
    logic                    reg_write;
    logic                    mem_read;
    logic                    mem_write;
    logic                    mem_to_reg;
    logic                    branch;
    logic                    alu_src;
    logic [1:0]              alu_op;
  } id_ex_t;

  logic [INS_MEM_SIZE-1:0] ins;
  logic [PC_SIZE-1:0]      pc;
  logic [6:0]              opc;
  logic [REG_ADDR-1:0]     rs1;
  logic [REG_ADDR-1:0]     rs2;
  logic [REG_ADDR-1:0]     rd;
  logic                    is_r;
  logic                    is_i;
  logic                    is_ld;
  logic                    is_st;
  logic                    is_br;
  logic                    use_rs2;
  logic                    load_use;
  logic [INS_MEM_SIZE-1:0] rs1_val;
  logic [INS_MEM_SIZE-1:0] rs2_val;
  logic [INS_MEM_SIZE-1:0] rf [NREG];
  id_ex_t                  dec;
  id_ex_t                  id_ex;

  assign ins = i_if_id_reg[INS_MEM_SIZE-1:0];
  assign pc  = i_if_id_reg[PC_SIZE+INS_MEM_SIZE-1:INS_MEM_SIZE];
  assign opc = ins[6:0];
  assign rs1 = ins[19:15];
  assign rs2 = ins[24:20];
  assign rd  = ins[11:7];

  assign is_r  = (opc == OP_R);
  assign is_i  = (opc == OP_I);
  assign is_ld = (opc == OP_LD);
  assign is_st = (opc == OP_ST);
  assign is_br = (opc == OP_BR);

  assign use_rs2 = is_r | is_st | is_br;

  assign load_use = i_ex_mem_read
                  & (i_ex_rd != '0)
                  & ((i_ex_rd == rs1)
                  | (use_rs2 & (i_ex_rd == rs2)));

  assign o_stall = load_use & ~i_flush;

  // Operand read; x0 is hardwired, same-cycle writeback bypasses the array.
  always_comb begin
    rs1_val = rf[rs1];
    rs2_val = rf[rs2];
    if (i_wb_we && (i_wb_addr == rs1)) rs1_val = i_wb_data;
    if (i_wb_we && (i_wb_addr == rs2)) rs2_val = i_wb_data;
    if (rs1 == '0) rs1_val = '0;
    if (rs2 == '0) rs2_val = '0;
  end

  // Register file; x0 writes are dropped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (i_wb_we && (i_wb_addr != '0)) begin
      rf[i_wb_addr] <= i_wb_data;
    end
  end

  // Control and immediate decode; anything unrecognised or killed is a bubble.
  always_comb begin
    dec = '0;
    unique case (1'b1)
      is_r: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_op    = 2'b10;
      end
      is_i: begin
        dec.valid     = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_op    = 2'b11;
        dec.imm       = {{20{ins[31]}}, ins[31:20]};
      end
      is_ld: begin
        dec.valid      = 1'b1;
        dec.reg_write  = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.alu_src    = 1'b1;
        dec.imm        = {{20{ins[31]}}, ins[31:20]};
      end
      is_st: begin
        dec.valid     = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm       = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      is_br: begin
        dec.valid  = 1'b1;
        dec.branch = 1'b1;
        dec.alu_op = 2'b01;
        dec.imm    = {{20{ins[31]}}, ins[7], ins[30:25],
                      ins[11:8], 1'b0};
      end
      default: ;
    endcase
    if (dec.valid) begin
      dec.pc       = pc;
      dec.rs1_data = rs1_val;
      dec.rs2_data = rs2_val;
      dec.rs1      = rs1;
      dec.rs2      = rs2;
      dec.rd       = rd;
      dec.funct3   = ins[14:12];
      dec.funct7b5 = ins[30];
    end
    if (i_flush || load_use) dec = '0;
  end

  // ID/EX pipeline register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) id_ex <= '0;
    else       id_ex <= dec;
  end

  assign o_id_ex_valid      = id_ex.valid;
  assign o_id_ex_pc         = id_ex.pc;
  assign o_id_ex_rs1_data   = id_ex.rs1_data;
  assign o_id_ex_rs2_data   = id_ex.rs2_data;
  assign o_id_ex_imm        = id_ex.imm;
  assign o_id_ex_rs1        = id_ex.rs1;
  assign o_id_ex_rs2        = id_ex.rs2;
  assign o_id_ex_rd         = id_ex.rd;
  assign o_id_ex_funct3     = id_ex.funct3;
  assign o_id_ex_funct7b5   = id_ex.funct7b5;
  assign o_id_ex_reg_write  = id_ex.reg_write;
  assign o_id_ex_mem_read   = id_ex.mem_read;
  assign o_id_ex_mem_write  = id_ex.mem_write;
  assign o_id_ex_mem_to_reg = id_ex.mem_to_reg;
  assign o_id_ex_branch     = id_ex.branch;
  assign o_id_ex_alu_src    = id_ex.alu_src;
  assign o_id_ex_alu_op     = id_ex.alu_op;

endmodule

// File: doc/inst_decode.md
# inst_decode

Instruction-decode stage of the 5-stage RISC-V (RV32I subset) pipeline. It consumes the packed IF/ID word {pc, instruction} produced by `inst_fetch`, reads a 32×32 register file, generates the immediate and control bits, and registers everything into the ID/EX pipeline register. It also owns the register-file writeback port and the load-use hazard stall back toward fetch.

## Interface
Parameters:
- `PC_SIZE`, 32: PC width.
- `INS_MEM_SIZE`, 32: instruction and data word width.
- `REG_ADDR`, 5: register index width.

Ports:
- `i_clk` in 1: single clock; all state updates on its rising edge.
- `i_rst` in 1: asynchronous, active-high reset.
- `i_if_id_reg` in PC_SIZE+INS_MEM_SIZE: bits [63:32] carry the pc and bits [31:0] carry the instruction.
- `i_wb_we` in 1: writeback enable.
- `i_wb_addr` in 5: writeback register index.
- `i_wb_data` in 32: writeback data.
- `i_ex_mem_read` in 1: the instruction currently in EX is a load.
- `i_ex_rd` in 5: destination register of that EX instruction.
- `i_flush` in 1: taken branch; the current IF/ID content is wrong-path.
- `o_stall` out 1: combinational; fetch must hold its PC and IF/ID register.
- `o_id_ex_valid` out 1: ID/EX holds a real instruction (0 means bubble).
- `o_id_ex_pc` out 32: registered pc.
- `o_id_ex_rs1_data` out 32: registered rs1 operand.
- `o_id_ex_rs2_data` out 32: registered rs2 operand.
- `o_id_ex_imm` out 32: registered sign-extended immediate.
- `o_id_ex_rs1`, `o_id_ex_rs2`, `o_id_ex_rd` out 5 each: registered register indices.
- `o_id_ex_funct3` out 3: registered funct3.
- `o_id_ex_funct7b5` out 1: registered instruction bit 30.
- `o_id_ex_reg_write`, `o_id_ex_mem_read`, `o_id_ex_mem_write`, `o_id_ex_mem_to_reg`, `o_id_ex_branch`, `o_id_ex_alu_src` out 1 each: registered control bits.
- `o_id_ex_alu_op` out 2: registered ALU class. 00 = add (load/store), 01 = branch compare, 10 = R-type, 11 = I-ALU.

## Operation
**Supported opcodes and decode**
- R-type (0110011): reg_write=1, alu_op=10, imm=0.
- I-ALU (0010011): reg_write=1, alu_src=1, alu_op=11, I-immediate.
- LOAD (0000011): reg_write=1, mem_read=1, mem_to_reg=1, alu_src=1, alu_op=00, I-immediate.
- STORE (0100011): mem_write=1, alu_src=1, alu_op=00, S-immediate.
- BRANCH (1100011): branch=1, alu_op=01, B-immediate.
- Any other opcode, including the all-zero reset word, decodes as a bubble: valid=0 and all control bits 0.

**Immediates (sign-extended to 32 bits)**
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.

**Register file**
- 32×32 array; x0 reads as 0 and writes to x0 are ignored.
- Write occurs on the rising edge when `i_wb_we`=1.
- Write-through: if `i_wb_we`=1 and `i_wb_addr` equals rs1 or rs2 (and is nonzero), the read returns `i_wb_data` in the same cycle.

**Hazard detection**
- rs2 counts as used only for R-type, STORE and BRANCH.
- Load-use condition: `i_ex_mem_read`=1, `i_ex_rd`≠0, and `i_ex_rd` equals rs1, or equals rs2 when rs2 is used.
- `o_stall` = load-use condition AND NOT `i_flush`.
- While `o_stall`=1, ID/EX loads a bubble; the IF/ID input is expected to be unchanged on the next cycle.

**Next ID/EX value, in priority order**
1. `i_flush`: bubble.
2. `o_stall`: bubble.
3. Otherwise: the decoded instruction.

A bubble sets valid and all control bits to 0. Data fields may be any value but are driven to 0.

## Timing
- While `i_rst`=1, asynchronously: all `o_id_ex_*` outputs are 0 and every register-file entry is 0. `o_stall` follows its combinational definition.
- Reset asserted mid-operation clears all state immediately. There is no partial-commit hold.
- Latency: the IF/ID value present before rising edge N appears on the ID/EX outputs after edge N (1 cycle).
- `o_stall` is combinational from `i_if_id_reg`, `i_ex_mem_read`, `i_ex_rd` and `i_flush`, and is valid within the same cycle.
- A load-use pair produces exactly one bubble, because the load leaves EX on the next edge.
- Writeback and decode read of the same register in the same cycle return the new data via write-through. The array itself is updated at the edge.

## Test plan
- **Reset:** drive `i_rst`=1 for 2 cycles mid-stream -> every `o_id_ex_*` is 0; after release, a read of x1–x31 returns 0.
- **R-type read:** write x5=0xDEADBEEF and x6=0x00000001, then IF/ID={0x00000010, 0x006283B3} (add x7,x5,x6) -> next cycle: pc=0x10, rs1_data=0xDEADBEEF, rs2_data=1, rd=7, reg_write=1, alu_op=10, valid=1.
- **Write-through:** present add x7,x5,x6 while `i_wb_we`=1, `i_wb_addr`=5, `i_wb_data`=0x12345678 in the same cycle -> rs1_data=0x12345678. Separately, a writeback to x0 leaves x0 reading 0.
- **Branch immediate:** IF/ID instruction 0xFE208CE3 (beq x1,x2,-8) -> imm=0xFFFFFFF8, branch=1, alu_op=01, reg_write=0.
- **Load-use:** `i_ex_mem_read`=1, `i_ex_rd`=5, instruction uses rs1=5 -> `o_stall`=1 for that cycle and the next ID/EX is valid=0. With `i_ex_rd`=0 instead -> no stall.
- **Flush priority:** the load-use condition is true and `i_flush`=1 -> `o_stall`=0 and ID/EX is a bubble. An unsupported opcode (0x00000000) -> valid=0 with all control bits 0.
